// File: rtl/tdm_stream_merger_if.sv
// Handshake bundle for tdm_stream_merger: config port, three router
// input streams and the merged output stream.
interface tdm_stream_merger_if #(
   parameter int DATA_WIDTH       = 64,
   parameter int CONFIG_BIT_WIDTH = 30
);
   logic [CONFIG_BIT_WIDTH-1:0] s_axi_config_data;
   logic                        s_axi_config_valid;
   logic                        s_axi_config_ready;

   logic [DATA_WIDTH-1:0] in_axi_data_1;
   logic [DATA_WIDTH-1:0] in_axi_data_2;
   logic [DATA_WIDTH-1:0] in_axi_data_3;
   logic                  in_axi_valid_1;
   logic                  in_axi_valid_2;
   logic                  in_axi_valid_3;
   logic                  in_axi_ready_1;
   logic                  in_axi_ready_2;
   logic                  in_axi_ready_3;

   logic [DATA_WIDTH-1:0] m_axi_data;
   logic                  m_axi_valid;
   logic                  m_axi_ready;
   logic [1:0]            m_axi_id;
   logic                  m_axi_last;
   logic                  m_axi_eof;

   modport master (
      output s_axi_config_data, s_axi_config_valid,
      input  s_axi_config_ready,
      output in_axi_data_1, in_axi_data_2, in_axi_data_3,
      output in_axi_valid_1, in_axi_valid_2, in_axi_valid_3,
      input  in_axi_ready_1, in_axi_ready_2, in_axi_ready_3,
      input  m_axi_data, m_axi_valid, m_axi_id,
      input  m_axi_last, m_axi_eof,
      output m_axi_ready
   );

   modport slave (
      input  s_axi_config_data, s_axi_config_valid,
      output s_axi_config_ready,
      input  in_axi_data_1, in_axi_data_2, in_axi_data_3,
      input  in_axi_valid_1, in_axi_valid_2, in_axi_valid_3,
      output in_axi_ready_1, in_axi_ready_2, in_axi_ready_3,
      output m_axi_data, m_axi_valid, m_axi_id,
      output m_axi_last, m_axi_eof,
      input  m_axi_ready
   );
endinterface

// File: rtl/tdm_stream_merger.sv
// Merges three router streams into one TDM stream: per round, prb_N beats
// from each stream N still within its symbol count, via one output register.
module tdm_stream_merger #(
   parameter int DATA_WIDTH       = 64,
   parameter int CONFIG_BIT_WIDTH = 30
) (
   input logic                clk,
   input logic                reset,
   tdm_stream_merger_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S2   = 2'd2,
      S3   = 2'd3
   } state_t;

   // Fields packed {f3, f2, f1}, five bits each.
   function automatic logic [2:0] elig(
      input logic [14:0] s,
      input logic [14:0] p,
      input logic [5:0]  r
   );
      logic [2:0] v;
      for (int i = 0; i < 3; i++)
         v[i] = (p[i*5 +: 5] != 5'd0) && ({1'b0, s[i*5 +: 5]} > r);
      return v;
   endfunction

   function automatic state_t pick(input logic [2:0] v);
      state_t s;
      if (v[0])      s = S1;
      else if (v[1]) s = S2;
      else if (v[2]) s = S3;
      else           s = IDLE;
      return s;
   endfunction

   state_t                      state;
   state_t                      nxt;
   state_t                      same_s;
   state_t                      later_s;
   state_t                      first_s;
   logic [14:0]                 sym_r;
   logic [14:0]                 prb_r;
   logic [4:0]                  round;
   logic [4:0]                  nxt_round;
   logic [5:0]                  round_inc;
   logic [4:0]                  beat_cnt;
   logic [4:0]                  cur_prb;
   logic [2:0]                  hi_mask;
   logic                        cur_valid;
   logic [DATA_WIDTH-1:0]       cur_data;
   logic                        out_free;
   logic                        hs;
   logic                        blk_end;
   logic                        cfg_hs;
   logic                        cfg_ready;
   logic [CONFIG_BIT_WIDTH-1:0] cfg_d;
   logic [14:0]                 cfg_sym;
   logic [14:0]                 cfg_prb;

   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic [1:0]            m_id;
   logic                  m_last;
   logic                  m_eof;

   assign cfg_d   = bus.s_axi_config_data;
   assign cfg_sym = {cfg_d[9:5], cfg_d[19:15], cfg_d[29:25]};
   assign cfg_prb = {cfg_d[4:0], cfg_d[14:10], cfg_d[24:20]};
   assign cfg_hs  = cfg_ready && bus.s_axi_config_valid;
   assign first_s = pick(elig(cfg_sym, cfg_prb, 6'd0));

   assign out_free = !m_valid || bus.m_axi_ready;

   assign bus.in_axi_ready_1 = (state == S1) && out_free;
   assign bus.in_axi_ready_2 = (state == S2) && out_free;
   assign bus.in_axi_ready_3 = (state == S3) && out_free;

   always_comb begin
      cur_valid = 1'b0;
      cur_data  = '0;
      cur_prb   = '0;
      hi_mask   = '0;
      unique case (state)
         S1: begin
            cur_valid = bus.in_axi_valid_1;
            cur_data  = bus.in_axi_data_1;
            cur_prb   = prb_r[4:0];
            hi_mask   = 3'b110;
         end
         S2: begin
            cur_valid = bus.in_axi_valid_2;
            cur_data  = bus.in_axi_data_2;
            cur_prb   = prb_r[9:5];
            hi_mask   = 3'b100;
         end
         S3: begin
            cur_valid = bus.in_axi_valid_3;
            cur_data  = bus.in_axi_data_3;
            cur_prb   = prb_r[14:10];
            hi_mask   = 3'b000;
         end
         default: ;
      endcase
   end

   assign hs      = cur_valid && out_free;
   assign blk_end = hs && ((beat_cnt + 5'd1) == cur_prb);

   // Next block: a later stream in this round, else the next round.
   assign round_inc = {1'b0, round} + 6'd1;
   assign same_s    = pick(elig(sym_r, prb_r, {1'b0, round}) & hi_mask);
   assign later_s   = pick(elig(sym_r, prb_r, round_inc));
   assign nxt       = (same_s != IDLE) ? same_s : later_s;
   assign nxt_round = (same_s != IDLE) ? round : round_inc[4:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         round     <= '0;
         beat_cnt  <= '0;
         sym_r     <= '0;
         prb_r     <= '0;
         cfg_ready <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_id      <= '0;
         m_last    <= 1'b0;
         m_eof     <= 1'b0;
      end else begin
         if (hs) begin
            m_valid <= 1'b1;
            m_data  <= cur_data;
            m_id    <= 2'(state);
            m_last  <= blk_end;
            m_eof   <= blk_end && (nxt == IDLE);
         end else if (bus.m_axi_ready) begin
            m_valid <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               cfg_ready <= !cfg_hs || (first_s == IDLE);
               if (cfg_hs) begin
                  sym_r    <= cfg_sym;
                  prb_r    <= cfg_prb;
                  round    <= '0;
                  beat_cnt <= '0;
                  state    <= first_s;
               end
            end
            default: begin
               if (blk_end) begin
                  beat_cnt  <= '0;
                  state     <= nxt;
                  round     <= (nxt == IDLE) ? 5'd0 : nxt_round;
                  cfg_ready <= (nxt == IDLE);
               end else if (hs) begin
                  beat_cnt <= beat_cnt + 5'd1;
               end
            end
         endcase
      end
   end

   assign bus.s_axi_config_ready = cfg_ready;
   assign bus.m_axi_valid        = m_valid;
   assign bus.m_axi_data         = m_data;
   assign bus.m_axi_id           = m_id;
   assign bus.m_axi_last         = m_last;
   assign bus.m_axi_eof          = m_eof;

endmodule

// File: tb/tb_tdm_stream_merger.sv
// Bench for tdm_stream_merger: queue model of the TDM schedule, counting
// sources, and directed configs with hand-computed pins.
module tb_tdm_stream_merger;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tdm_stream_merger_if #(.DATA_WIDTH(64), .CONFIG_BIT_WIDTH(30)) bus ();

   tdm_stream_merger #(.DATA_WIDTH(64), .CONFIG_BIT_WIDTH(30)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  id;
      logic [63:0] data;
      logic        last;
      logic        eof;
   } beat_t;

   beat_t exp_q[$];
   beat_t bq[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    src_cnt[4];
   int    mdl_cnt[4];
   bit    sv[4];
   int    in_hs_total = 0;
   int    rdy23 = 0;
   int    beats_seen = 0;
   int    last_wait = 0;
   int    in_cyc[$];
   int    out_cyc[$];
   bit    gap_mode = 0;
   bit    tog_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mk(int k, int n);
      return {8'(k), 24'h0, 32'(n)};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic apply_src();
      bus.in_axi_valid_1 = sv[1];
      bus.in_axi_valid_2 = sv[2];
      bus.in_axi_valid_3 = sv[3];
      bus.in_axi_data_1  = mk(1, src_cnt[1]);
      bus.in_axi_data_2  = mk(2, src_cnt[2]);
      bus.in_axi_data_3  = mk(3, src_cnt[3]);
   endtask

   // Sources and sink: handshakes sampled at negedge, applied after posedge.
   initial begin : drv
      bit hs[4];
      bit rok;
      int hc;
      bus.s_axi_config_valid = 1'b0;
      bus.s_axi_config_data  = '0;
      bus.m_axi_ready        = 1'b1;
      for (int k = 1; k < 4; k++) sv[k] = 1'b1;
      apply_src();
      forever begin
         @(negedge clk);
         hs[1] = bus.in_axi_valid_1 && bus.in_axi_ready_1;
         hs[2] = bus.in_axi_valid_2 && bus.in_axi_ready_2;
         hs[3] = bus.in_axi_valid_3 && bus.in_axi_ready_3;
         hc = cyc;
         if (bus.in_axi_ready_2 || bus.in_axi_ready_3) rdy23++;
         @(posedge clk);
         rok = reset;
         for (int k = 1; k < 4; k++) begin
            if (rok && hs[k]) begin
               src_cnt[k]++;
               in_hs_total++;
               in_cyc.push_back(hc);
            end
         end
         #1;
         for (int k = 1; k < 4; k++)
            if (!sv[k] || (hs[k] && rok))
               sv[k] = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
         apply_src();
         bus.m_axi_ready = tog_mode ? !bus.m_axi_ready : 1'b1;
      end
   end

   // Output compare against the model queue plus hold-while-stalled check.
   beat_t held;
   bit    held_v = 0;
   always @(negedge clk) begin
      beat_t e;
      if (!reset) begin
         held_v = 0;
      end else if (bus.m_axi_valid) begin
         if (held_v) begin
            checks++;
            if (bus.m_axi_id !== held.id || bus.m_axi_data !== held.data ||
                bus.m_axi_last !== held.last || bus.m_axi_eof !== held.eof) begin
               errors++;
               $display("FAIL stable: got id=%0d data=%0h required id=%0d data=%0h",
                        bus.m_axi_id, bus.m_axi_data, held.id, held.data);
            end
         end
         if (bus.m_axi_ready) begin
            beats_seen++;
            out_cyc.push_back(cyc);
            held_v = 0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got id=%0d data=%0h required none",
                        bus.m_axi_id, bus.m_axi_data);
            end else begin
               e = exp_q.pop_front();
               if (bus.m_axi_id !== e.id || bus.m_axi_data !== e.data ||
                   bus.m_axi_last !== e.last || bus.m_axi_eof !== e.eof) begin
                  errors++;
                  $display("FAIL beat: got id=%0d data=%0h last=%0b eof=%0b required id=%0d data=%0h last=%0b eof=%0b",
                           bus.m_axi_id, bus.m_axi_data, bus.m_axi_last,
                           bus.m_axi_eof, e.id, e.data, e.last, e.eof);
               end
            end
         end else begin
            held_v     = 1;
            held.id    = bus.m_axi_id;
            held.data  = bus.m_axi_data;
            held.last  = bus.m_axi_last;
            held.eof   = bus.m_axi_eof;
         end
      end else if (held_v) begin
         held_v = 0;
         checks++;
         errors++;
         $display("FAIL dropped: got valid=0 required valid=1");
      end
   end

   // Schedule model: rounds outermost, streams 1..3, prb beats each.
   task automatic build(int s1, int p1, int s2, int p2, int s3, int p3);
      int    s[3];
      int    p[3];
      int    tot;
      beat_t b;
      s   = '{s1, s2, s3};
      p   = '{p1, p2, p3};
      tot = s1 * p1 + s2 * p2 + s3 * p3;
      bq.delete();
      for (int r = 0; r < 32; r++)
         for (int k = 0; k < 3; k++)
            if (p[k] > 0 && r < s[k])
               for (int j = 1; j <= p[k]; j++) begin
                  b.id   = 2'(k + 1);
                  b.data = '0;
                  b.last = (j == p[k]);
                  b.eof  = (bq.size() + 1 == tot);
                  bq.push_back(b);
               end
   endtask

   task automatic send_cfg(int s1, int p1, int s2, int p2, int s3, int p3);
      beat_t e;
      int    n;
      build(s1, p1, s2, p2, s3, p3);
      @(posedge clk);
      #1;
      bus.s_axi_config_data  = {5'(s1), 5'(p1), 5'(s2), 5'(p2), 5'(s3), 5'(p3)};
      bus.s_axi_config_valid = 1'b1;
      n = 0;
      for (n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (bus.s_axi_config_ready) break;
      end
      last_wait = n;
      if (!bus.s_axi_config_ready) begin
         checks++;
         errors++;
         $display("FAIL cfg_timeout: got ready=0 required ready=1");
      end
      foreach (bq[i]) begin
         e      = bq[i];
         e.data = mk(int'(e.id), mdl_cnt[e.id]);
         mdl_cnt[e.id]++;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.s_axi_config_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int n = 0; n < 3000 && !done; n++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && bus.s_axi_config_ready && !bus.m_axi_valid;
      end
      check("drain", 64'(done), 64'd1);
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_valid"}, 64'(bus.m_axi_valid), 64'd0);
      check({tag, "_last"}, 64'(bus.m_axi_last), 64'd0);
      check({tag, "_eof"}, 64'(bus.m_axi_eof), 64'd0);
      check({tag, "_id"}, 64'(bus.m_axi_id), 64'd0);
      check({tag, "_data"}, bus.m_axi_data, 64'd0);
      check({tag, "_in_ready"},
            64'({bus.in_axi_ready_1, bus.in_axi_ready_2, bus.in_axi_ready_3}),
            64'd0);
      check({tag, "_cfg_ready"}, 64'(bus.s_axi_config_ready), 64'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int ids_ref[11];
      int last_ref[11];
      int bad;
      int b0;
      int base;

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      #1 reset = 1'b1;
      #1 check("cfg_ready_pre_edge", 64'(bus.s_axi_config_ready), 64'd0);
      @(posedge clk);
      #1 check("cfg_ready_post_edge", 64'(bus.s_axi_config_ready), 64'd1);

      // Model pin for symbol=(2,1,3) prb=(3,2,1)
      ids_ref  = '{1, 1, 1, 2, 2, 3, 1, 1, 1, 3, 3};
      last_ref = '{0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
      build(2, 3, 1, 2, 3, 1);
      check("pin27_size", 64'(bq.size()), 64'd11);
      bad = 0;
      foreach (bq[i])
         if (i < 11 && (int'(bq[i].id) != ids_ref[i] ||
             int'(bq[i].last) != last_ref[i] || bq[i].eof != (i == 10)))
            bad++;
      check("pin27_seq", 64'(bad), 64'd0);

      // All ready: 11 back-to-back beats, latency 1
      in_cyc.delete();
      out_cyc.delete();
      send_cfg(2, 3, 1, 2, 3, 1);
      drain();
      check("r27_beats", 64'(out_cyc.size()), 64'd11);
      if (out_cyc.size() == 11 && in_cyc.size() > 0) begin
         check("r27_no_gaps", 64'(out_cyc[10] - out_cyc[0]), 64'd10);
         check("r27_latency", 64'(out_cyc[0] - in_cyc[0]), 64'd1);
      end

      // All prb zero: nothing happens
      build(5, 0, 5, 0, 5, 0);
      check("pin28_size", 64'(bq.size()), 64'd0);
      b0 = beats_seen;
      send_cfg(5, 0, 5, 0, 5, 0);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (!bus.s_axi_config_ready || bus.m_axi_valid ||
             bus.in_axi_ready_1 || bus.in_axi_ready_2 || bus.in_axi_ready_3)
            bad++;
      end
      check("r28_quiet", 64'(bad), 64'd0);
      check("r28_beats", 64'(beats_seen - b0), 64'd0);

      // symbol=(1,0,1) prb=(2,4,0): stream 1 only
      build(1, 2, 0, 4, 1, 0);
      check("pin29_size", 64'(bq.size()), 64'd2);
      b0 = rdy23;
      base = beats_seen;
      send_cfg(1, 2, 0, 4, 1, 0);
      drain();
      check("r29_beats", 64'(beats_seen - base), 64'd2);
      check("r29_rdy23", 64'(rdy23 - b0), 64'd0);

      // Stalling sink and gappy sources
      gap_mode = 1;
      tog_mode = 1;
      base = beats_seen;
      send_cfg(2, 3, 1, 2, 3, 1);
      drain();
      check("r30_beats", 64'(beats_seen - base), 64'd11);
      gap_mode = 0;
      tog_mode = 0;
      repeat (3) @(negedge clk);

      // Reset after beat 4, then a 1/1/1 config
      base = beats_seen;
      send_cfg(2, 3, 1, 2, 3, 1);
      for (int n = 0; n < 200 && beats_seen - base < 4; n++) @(negedge clk);
      check("r31_reach4", 64'(beats_seen - base >= 4), 64'd1);
      #2 reset = 1'b0;
      #1 check_reset_outputs("r31");
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #2;
      for (int k = 1; k < 4; k++) mdl_cnt[k] = src_cnt[k];
      build(1, 1, 1, 1, 1, 1);
      bad = 0;
      foreach (bq[i])
         if (int'(bq[i].id) != i + 1 || !bq[i].last || bq[i].eof != (i == 2))
            bad++;
      check("pin31_size", 64'(bq.size()), 64'd3);
      check("pin31_seq", 64'(bad), 64'd0);
      base = beats_seen;
      send_cfg(1, 1, 1, 1, 1, 1);
      drain();
      check("r31_beats", 64'(beats_seen - base), 64'd3);

      // Second config offered while busy
      base = in_hs_total;
      send_cfg(2, 3, 1, 2, 3, 1);
      send_cfg(1, 1, 1, 1, 1, 1);
      check("r32_blocked", 64'(last_wait > 1), 64'd1);
      check("r32_first_done", 64'(in_hs_total - base), 64'd11);
      drain();
      check("r32_total", 64'(in_hs_total - base), 64'd14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
